// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle radix-2 restoring divider for RV32M
//                DIV/DIVU/REM/REMU. Accepts operands from execute, stalls
//                the pipeline while iterating, and presents a one-cycle
//                result strobe with the sign-corrected quotient/remainder.
//  Options     : DIV_EARLY_OUT_EN - when defined, operations whose absolute
//                dividend is below the absolute divisor finish on the
//                one-cycle path (quotient 0, remainder = dividend).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req_i,
  input  logic [2:0]      alu_d_ops_i,
  input  logic [XLEN-1:0] alu_operand_1_i,
  input  logic [XLEN-1:0] alu_operand_2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] C_OP_DIV  = 3'd1;
  localparam logic [2:0] C_OP_DIVU = 3'd2;
  localparam logic [2:0] C_OP_REM  = 3'd3;
  localparam logic [2:0] C_OP_REMU = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN-1:0]   r_quo;      // starts as |dividend|, shifts out into r_rem
  logic [XLEN-1:0]   r_rem;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_rem_op;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------------------
  // Request decode and operand preparation
  // ---------------------------------------------------------------------------
  logic              w_op_div;
  logic              w_op_divu;
  logic              w_op_rem;
  logic              w_op_remu;
  logic              w_valid_op;
  logic              w_signed_op;
  logic              w_accept;
  logic              w_op1_neg;
  logic              w_op2_neg;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic              w_div_zero;
  logic              w_overflow;
  logic              w_early;
  logic              w_special;

  assign w_op_div    = (alu_d_ops_i == C_OP_DIV);
  assign w_op_divu   = (alu_d_ops_i == C_OP_DIVU);
  assign w_op_rem    = (alu_d_ops_i == C_OP_REM);
  assign w_op_remu   = (alu_d_ops_i == C_OP_REMU);
  assign w_valid_op  = w_op_div | w_op_divu | w_op_rem | w_op_remu;
  assign w_signed_op = w_op_div | w_op_rem;

  assign w_accept    = (r_state == S_IDLE) & div_req_i & w_valid_op & ~kill_i;

  assign w_op1_neg   = w_signed_op & alu_operand_1_i[XLEN-1];
  assign w_op2_neg   = w_signed_op & alu_operand_2_i[XLEN-1];
  assign w_abs1      = w_op1_neg ? -alu_operand_1_i : alu_operand_1_i;
  assign w_abs2      = w_op2_neg ? -alu_operand_2_i : alu_operand_2_i;

  assign w_div_zero  = (alu_operand_2_i == '0);
  // Most-negative / -1 cannot be represented; RISC-V defines the result.
  assign w_overflow  = w_signed_op
                     & (alu_operand_1_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (&alu_operand_2_i);

`ifdef DIV_EARLY_OUT_EN
  assign w_early     = ~w_div_zero & (w_abs1 < w_abs2);
`else
  assign w_early     = 1'b0;
`endif

  assign w_special   = w_div_zero | w_overflow | w_early;

  // ---------------------------------------------------------------------------
  // One restoring iteration: shift {rem, quo} left and trial-subtract.
  // The shifted remainder can reach XLEN+1 bits, so the no-borrow test is a
  // wide compare; the difference itself always fits in XLEN bits.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     w_shift;
  logic              w_no_borrow;
  logic [XLEN-1:0]   w_sub;
  logic [XLEN-1:0]   w_rem_next;

  assign w_shift     = {r_rem, r_quo[XLEN-1]};
  assign w_no_borrow = (w_shift >= {1'b0, r_divisor});
  assign w_sub       = w_shift[XLEN-1:0] - r_divisor;
  assign w_rem_next  = w_no_borrow ? w_sub : w_shift[XLEN-1:0];

  // ---------------------------------------------------------------------------
  // Sign correction and result selection
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   w_final_quo;
  logic [XLEN-1:0]   w_final_rem;
  logic [XLEN-1:0]   w_final;

  assign w_final_quo = r_q_neg ? -r_quo : r_quo;
  assign w_final_rem = r_r_neg ? -r_rem : r_rem;
  assign w_final     = r_rem_op ? w_final_rem : w_final_quo;

  // Live result in DONE, then the captured copy until the next operation.
  assign result_o    = (r_state == S_DONE) ? w_final : r_result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, stall request and result strobe
  always_comb begin
    w_next_state = r_state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = w_accept;
        if (w_accept) begin
          w_next_state = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done_o       = ~kill_i;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (kill_i) begin
      w_next_state = S_IDLE;
    end
  end

  // Operand capture on acceptance and the iterative datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_rem_op  <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CNT_W'(XLEN-1);
      r_divisor <= w_abs2;
      r_rem_op  <= w_op_rem | w_op_remu;
      if (w_div_zero) begin
        // Results are final as stored: no sign correction applies.
        r_quo   <= '1;
        r_rem   <= alu_operand_1_i;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
      end else if (w_overflow) begin
        r_quo   <= {1'b1, {(XLEN-1){1'b0}}};
        r_rem   <= '0;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
      end else if (w_early) begin
        r_quo   <= '0;
        r_rem   <= alu_operand_1_i;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
      end else begin
        r_quo   <= w_abs1;
        r_rem   <= '0;
        r_q_neg <= w_op1_neg ^ w_op2_neg;
        r_r_neg <= w_op1_neg;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_next;
      r_quo <= {r_quo[XLEN-2:0], w_no_borrow};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Hold the presented result after DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (r_state == S_DONE) begin
      r_result <= w_final;
    end
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Responder side of the execute-to-divider interface. Execute supplies the operands and the divide op; this block returns a stall indication and a one-cycle result strobe.
- Operands are captured on acceptance. The result is written to LSU through the execute result path.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- div_req_i  input  1  start request, sampled in IDLE only
- alu_d_ops_i  input  3  0 NONE, 1 DIV, 2 DIVU, 3 REM, 4 REMU; other codes treated as NONE
- alu_operand_1_i  input  XLEN  dividend
- alu_operand_2_i  input  XLEN  divisor
- kill_i  input  1  pipeline flush; aborts the operation
- busy_o  output  1  stall request to the pipeline
- done_o  output  1  result valid, one-cycle pulse
- result_o  output  XLEN  quotient or remainder

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset forces IDLE and clears the counter, dividend, divisor, quotient, remainder and sign/op registers.
- Reset values of outputs: busy_o=0, done_o=0, result_o=0.
- States:
  - IDLE, CALC, DONE.
- Acceptance:
  - Occurs in IDLE when div_req_i=1, alu_d_ops_i is a valid op, and kill_i=0.
  - On acceptance, latch op and operands. Take absolute values for DIV/REM. Record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
- Special cases (IDLE to DONE directly, 1-cycle path):
  - Divisor zero: quotient = all ones; remainder = dividend (unmodified).
  - Signed overflow, dividend 0x80000000 with divisor 0xFFFFFFFF for DIV/REM: quotient = 0x80000000; remainder = 0.
- Normal path:
  - IDLE to CALC, counter = XLEN-1.
  - In each CALC cycle, shift {rem, quo} left 1 and trial-subtract the divisor. If the subtraction does not borrow, keep it and set the quotient LSB.
  - After the cycle where counter=0, go to DONE. The counter decrements each cycle.
- Latency:
  - Acceptance cycle C0, CALC occupies C1..C32, done_o=1 in C33, IDLE in C34.
  - Special-case path: done_o=1 in C1.
- DONE state:
  - done_o=1 for exactly one cycle.
  - result_o = sign-corrected quotient for DIV/DIVU, or sign-corrected remainder for REM/REMU. Negate when the recorded sign is set; the unsigned ops never negate.
  - Next state is IDLE unconditionally.
  - result_o holds its value after DONE until the next acceptance. Consumers use it only with done_o.
- busy_o:
  - busy_o = (state==CALC) | (state==IDLE & div_req_i & valid op & ~kill_i).
  - busy_o is 0 in DONE, so the pipeline advances in the same cycle the result is presented.
- Kill:
  - kill_i=1 in any state forces IDLE at the next edge and suppresses done_o that cycle.
  - kill_i has priority over div_req_i in the same cycle.
  - Internal registers other than the state need not clear on kill.
- Requests and operand stability:
  - div_req_i in CALC or DONE is ignored; it is not queued.
  - Operand changes after acceptance have no effect.
- Reset mid-operation: reset asserted in any state returns to IDLE immediately. No done_o follows.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: in IDLE, if |dividend| < |divisor| (unsigned compare of the absolute values, divisor nonzero), go directly to DONE with quotient = 0 and remainder = original dividend. done_o is then in C1.
- When undefined: all non-special operations take the full 32 CALC cycles.
- Results are identical either way; only latency differs.

Test Plan:
- DIVU 100 / 7: done_o in C33, result_o=14. Repeat with REMU: result_o=2. busy_o high C0..C32, low in C33.
- DIV -100 / 7: result_o=0xFFFFFFF2 (-14). REM -100 / 7: result_o=0xFFFFFFFE (-2). DIV 100 / -7: result_o=-14.
- Divide by zero, DIV 5 / 0: done_o in C1, result_o=0xFFFFFFFF. REM 5 / 0: result_o=5. DIVU 0xFFFFFFFF / 0: result_o=0xFFFFFFFF.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF: result_o=0x80000000. REM with the same operands: result_o=0. Both complete with done_o in C1.
- Abort: start DIVU 1000/3, assert kill_i in C10. Required: IDLE in C11, no done_o, busy_o=0. A new DIVU 9/3 accepted in C12 gives result_o=3 with done_o in C45.
- Reset mid-CALC returns to IDLE with outputs at their reset values. With DIV_EARLY_OUT_EN defined, DIVU 3 / 10 gives done_o in C1 and result_o=0; REMU 3 / 10 gives result_o=3. With the macro undefined, the same cases complete in C33 with identical values.
